uart_frame_parser: RTL and testbench



---
 rtl/uart_frame_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 51 +++++
 rtl/uart_frame_parser.sv | 166 ++++++++++++++++
 tb/tb_uart_frame_parser.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared constants and state encoding for the host link frame parser
package uart_frame_pkg;

   localparam logic [7:0] SOF = 8'hA5;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      LEN,
      PAYLOAD,
      CHK
   } state_t;

   localparam logic [2:0] ERR_NONE = 3'd0;
   localparam logic [2:0] ERR_CHK  = 3'd1;
   localparam logic [2:0] ERR_LEN  = 3'd2;
   localparam logic [2:0] ERR_TMO  = 3'd3;
   localparam logic [2:0] ERR_OVF  = 3'd4;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered occupancy count
module sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   // full is judged on the pre-pop count, so a push into a full FIFO is dropped even if a pop happens
   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - parses SOF/CMD/LEN/payload/XOR frames from the UART receiver
// and streams payload bytes through a FIFO with per-frame status pulses.
module uart_frame_parser
   import uart_frame_pkg::*;
#(
   parameter int MAX_LEN        = 64,
   parameter int FIFO_DEPTH     = 16,
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_done,
   output logic [7:0] m_data,
   output logic       m_last,
   output logic       m_valid,
   input  logic       m_ready,
   output logic [7:0] cmd_out,
   output logic       frame_start,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [2:0] err_code
);

   localparam int              TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int              CW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
   localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

   state_t        state_q, state_d;
   logic [7:0]    chk_q, chk_d;
   logic [7:0]    rem_q, rem_d;
   logic [7:0]    cmd_q, cmd_d;
   logic          ovf_q, ovf_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          start_q, start_d;
   logic          ok_q, ok_d;
   logic          err_q, err_d;
   logic [2:0]    code_q, code_d;

   logic          push;
   logic [8:0]    push_data;
   logic          pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [8:0]    fifo_q;
   logic [CW-1:0] fifo_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         chk_q   <= '0;
         rem_q   <= '0;
         cmd_q   <= '0;
         ovf_q   <= 1'b0;
         tmo_q   <= '0;
         start_q <= 1'b0;
         ok_q    <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= ERR_NONE;
      end else begin
         state_q <= state_d;
         chk_q   <= chk_d;
         rem_q   <= rem_d;
         cmd_q   <= cmd_d;
         ovf_q   <= ovf_d;
         tmo_q   <= tmo_d;
         start_q <= start_d;
         ok_q    <= ok_d;
         err_q   <= err_d;
         code_q  <= code_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      chk_d     = chk_q;
      rem_d     = rem_q;
      cmd_d     = cmd_q;
      ovf_d     = ovf_q;
      start_d   = 1'b0;
      ok_d      = 1'b0;
      err_d     = 1'b0;
      code_d    = code_q;
      push      = 1'b0;
      push_data = '0;
      tmo_d     = (rx_done || state_q == IDLE) ? '0 : tmo_q + TW'(1);

      if (rx_done) begin
         unique case (state_q)
            IDLE: if (rx_data == SOF) state_d = CMD;
            CMD: begin
               cmd_d   = rx_data;
               chk_d   = rx_data;
               state_d = LEN;
            end
            LEN: begin
               chk_d = chk_q ^ rx_data;
               if (rx_data > MAX_LEN_B) begin
                  err_d   = 1'b1;
                  code_d  = ERR_LEN;
                  state_d = IDLE;
               end else begin
                  start_d = 1'b1;
                  rem_d   = rx_data;
                  ovf_d   = 1'b0;
                  state_d = (rx_data == 8'd0) ? CHK : PAYLOAD;
               end
            end
            PAYLOAD: begin
               chk_d     = chk_q ^ rx_data;
               push      = 1'b1;
               push_data = {rem_q == 8'd1, rx_data};
               if (fifo_full) ovf_d = 1'b1;
               rem_d     = rem_q - 8'd1;
               if (rem_q == 8'd1) state_d = CHK;
            end
            CHK: begin
               state_d = IDLE;
               if (ovf_q) begin
                  err_d  = 1'b1;
                  code_d = ERR_OVF;
               end else if (rx_data != chk_q) begin
                  err_d  = 1'b1;
                  code_d = ERR_CHK;
               end else begin
                  ok_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end else if (state_q != IDLE && tmo_q == TMO_LAST) begin
         err_d   = 1'b1;
         code_d  = ERR_TMO;
         state_d = IDLE;
         tmo_d   = '0;
      end
   end

   sync_fifo #(
      .WIDTH (9),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_data),
      .full      (fifo_full),
      .pop       (pop),
      .pop_data  (fifo_q),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // gate the read port so stale RAM contents never show on the stream while empty
   assign m_valid     = (fifo_count != '0);
   assign pop         = m_valid && m_ready;
   assign m_data      = fifo_empty ? 8'h00 : fifo_q[7:0];
   assign m_last      = !fifo_empty && fifo_q[8];
   assign cmd_out     = cmd_q;
   assign frame_start = start_q;
   assign frame_ok    = ok_q;
   assign frame_err   = err_q;
   assign err_code    = code_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb/tb_uart_frame_parser.sv - randomized and directed bench with a frame-level reference model
module tb_uart_frame_parser;
   import uart_frame_pkg::*;

   localparam int MAXL  = 64;
   localparam int DEPTH = 16;
   localparam int TMO   = 200;

   typedef struct packed {
      logic [1:0] kind;   // 0 start, 1 ok, 2 err
      logic [2:0] code;
      logic [7:0] cmd;
   } stat_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_done = 1'b0;
   logic       m_ready = 1'b0;
   logic [7:0] m_data;
   logic       m_last;
   logic       m_valid;
   logic [7:0] cmd_out;
   logic       frame_start;
   logic       frame_ok;
   logic       frame_err;
   logic [2:0] err_code;

   logic [8:0] exp_stream[$];
   stat_t      exp_stat[$];
   logic [7:0] pq[$];
   int         n_checks = 0;
   int         n_errors = 0;
   int         n_xfer = 0;
   bit         rand_ready = 1'b0;
   logic       ready_force = 1'b1;
   logic [8:0] mon_e;

   uart_frame_parser #(
      .MAX_LEN        (MAXL),
      .FIFO_DEPTH     (DEPTH),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_data     (rx_data),
      .rx_done     (rx_done),
      .m_data      (m_data),
      .m_last      (m_last),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .cmd_out     (cmd_out),
      .frame_start (frame_start),
      .frame_ok    (frame_ok),
      .frame_err   (frame_err),
      .err_code    (err_code)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic take_status(input logic [1:0] kind);
      stat_t s;
      check_eq("status_expected", 32'(exp_stat.size() != 0), 32'd1);
      if (exp_stat.size() != 0) begin
         s = exp_stat.pop_front();
         check_eq("status_kind", 32'(kind), 32'(s.kind));
         if (kind == 2'd0) check_eq("cmd_out", 32'(cmd_out), 32'(s.cmd));
         if (kind == 2'd2) check_eq("err_code", 32'(err_code), 32'(s.code));
      end
   endtask

   always @(posedge clk) begin
      #1;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (m_valid && m_ready) begin
            check_eq("stream_expected", 32'(exp_stream.size() != 0), 32'd1);
            if (exp_stream.size() != 0) begin
               mon_e = exp_stream.pop_front();
               check_eq("m_data", 32'(m_data), 32'(mon_e[7:0]));
               check_eq("m_last", 32'(m_last), 32'(mon_e[8]));
               n_xfer++;
            end
         end
         if (frame_start) take_status(2'd0);
         if (frame_ok)    take_status(2'd1);
         if (frame_err)   take_status(2'd2);
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      repeat (gap) @(posedge clk);
      @(posedge clk);
      #1;
      rx_data = b;
      rx_done = 1'b1;
      @(posedge clk);
      #1;
      rx_done = 1'b0;
      rx_data = 8'($urandom);
   endtask

   // Reference model: room = bytes the FIFO can absorb during this frame
   task automatic run_frame(input logic [7:0] cmd, input logic [7:0] len, input logic [7:0] pay[$],
                            input logic [7:0] chk_byte, input int room, input int max_gap);
      logic [7:0] sum;
      if (int'(len) > MAXL) begin
         exp_stat.push_back({2'd2, ERR_LEN, cmd});
      end else begin
         exp_stat.push_back({2'd0, ERR_NONE, cmd});
         sum = cmd ^ len;
         for (int i = 0; i < int'(len); i++) begin
            sum ^= pay[i];
            if (i < room) exp_stream.push_back({i == int'(len) - 1, pay[i]});
         end
         if (int'(len) > room)  exp_stat.push_back({2'd2, ERR_OVF, cmd});
         else if (chk_byte != sum) exp_stat.push_back({2'd2, ERR_CHK, cmd});
         else                   exp_stat.push_back({2'd1, ERR_NONE, cmd});
      end
      send_byte(SOF, $urandom_range(0, max_gap));
      send_byte(cmd, $urandom_range(0, max_gap));
      send_byte(len, $urandom_range(0, max_gap));
      if (int'(len) <= MAXL) begin
         for (int i = 0; i < int'(len); i++) send_byte(pay[i], $urandom_range(0, max_gap));
         send_byte(chk_byte, $urandom_range(0, max_gap));
      end
   endtask

   task automatic wait_drain();
      int k = 0;
      while ((exp_stream.size() != 0 || exp_stat.size() != 0) && k < 1000) begin
         @(posedge clk);
         k++;
      end
      repeat (3) @(posedge clk);
      #1;
      check_eq("drain_stream", 32'(exp_stream.size()), 32'd0);
      check_eq("drain_status", 32'(exp_stat.size()), 32'd0);
      check_eq("drain_m_valid", 32'(m_valid), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_m_valid"}, 32'(m_valid), 32'd0);
      check_eq({tag, "_m_data"}, 32'(m_data), 32'd0);
      check_eq({tag, "_m_last"}, 32'(m_last), 32'd0);
      check_eq({tag, "_cmd_out"}, 32'(cmd_out), 32'd0);
      check_eq({tag, "_frame_start"}, 32'(frame_start), 32'd0);
      check_eq({tag, "_frame_ok"}, 32'(frame_ok), 32'd0);
      check_eq({tag, "_frame_err"}, 32'(frame_err), 32'd0);
      check_eq({tag, "_err_code"}, 32'(err_code), 32'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int x0;
      int kind;
      logic [7:0] cmd;
      logic [7:0] len;
      logic [7:0] chk;

      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;

      // basic two-byte frame
      pq = '{8'h10, 8'h20};
      run_frame(8'h01, 8'h02, pq, 8'h33, 255, 2);
      wait_drain();

      // zero-length frames: good then bad checksum
      pq.delete();
      run_frame(8'h07, 8'h00, pq, 8'h07, 255, 2);
      wait_drain();
      run_frame(8'h07, 8'h00, pq, 8'h06, 255, 2);
      wait_drain();

      // LEN one above the limit, then a normal frame
      run_frame(8'h01, 8'h41, pq, 8'h00, 255, 2);
      wait_drain();
      pq = '{8'hA5, 8'h5A, 8'hFF};
      run_frame(8'h3C, 8'h03, pq, 8'h3C ^ 8'h03 ^ 8'hA5 ^ 8'h5A ^ 8'hFF, 255, 2);
      wait_drain();

      // inter-byte timeout after one of three payload bytes
      exp_stat.push_back({2'd0, ERR_NONE, 8'h01});
      exp_stream.push_back({1'b0, 8'hAA});
      exp_stat.push_back({2'd2, ERR_TMO, 8'h01});
      send_byte(SOF, 0);
      send_byte(8'h01, 0);
      send_byte(8'h03, 0);
      send_byte(8'hAA, 0);
      k = 0;
      while (k < 2 * TMO) begin
         @(posedge clk);
         #1;
         k++;
         if (frame_err) break;
      end
      check_eq("tmo_latency", 32'(k), 32'(TMO));
      wait_drain();

      // overflow: consumer stalled, LEN=20
      ready_force = 1'b0;
      repeat (2) @(posedge clk);
      pq.delete();
      chk = 8'h09 ^ 8'd20;
      for (int i = 0; i < 20; i++) begin
         pq.push_back(8'($urandom));
         chk ^= pq[i];
      end
      run_frame(8'h09, 8'd20, pq, chk, DEPTH, 1);
      repeat (5) @(posedge clk);
      #1;
      check_eq("ovf_err_seen", 32'(exp_stat.size()), 32'd0);
      check_eq("ovf_m_valid_held", 32'(m_valid), 32'd1);
      x0 = n_xfer;
      ready_force = 1'b1;
      wait_drain();
      check_eq("ovf_transfers", 32'(n_xfer - x0), 32'd16);

      // reset in the middle of a payload with three bytes buffered
      ready_force = 1'b0;
      repeat (2) @(posedge clk);
      exp_stat.push_back({2'd0, ERR_NONE, 8'h02});
      send_byte(SOF, 0);
      send_byte(8'h02, 0);
      send_byte(8'h05, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      send_byte(8'h33, 0);
      @(posedge clk);
      #1;
      check_eq("pre_rst_m_valid", 32'(m_valid), 32'd1);
      check_eq("pre_rst_status", 32'(exp_stat.size()), 32'd0);
      rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      exp_stream.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      ready_force = 1'b1;
      pq = '{8'h01, 8'h02, 8'h04, 8'h08};
      run_frame(8'h55, 8'h04, pq, 8'h55 ^ 8'h04 ^ 8'h0F, 255, 2);
      wait_drain();

      // randomized frames with a stalling consumer
      rand_ready = 1'b1;
      for (int f = 0; f < 40; f++) begin
         repeat ($urandom_range(0, 2)) begin
            logic [7:0] g;
            g = 8'($urandom);
            if (g == SOF) g = 8'h00;
            send_byte(g, $urandom_range(0, 3));
         end
         kind = $urandom_range(0, 9);
         cmd  = 8'($urandom);
         pq.delete();
         if (kind == 0) begin
            len = 8'($urandom_range(MAXL + 1, 255));
            chk = 8'h00;
         end else begin
            len = 8'($urandom_range(0, 12));
            chk = cmd ^ len;
            for (int i = 0; i < int'(len); i++) begin
               pq.push_back(8'($urandom));
               chk ^= pq[i];
            end
            if (kind <= 2) chk ^= 8'($urandom_range(1, 255));
         end
         run_frame(cmd, len, pq, chk, 255, 3);
         wait_drain();
      end
      rand_ready = 1'b0;
      ready_force = 1'b1;
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
